obuf_arb_data: RTL and testbench

- Output-port stage directly downstream of the per-direction input data buffers of a mesh node.
- Round-robin arbitrates among 5 input-buffer requesters and returns a one-hot grant.
- Captures the granted payload into a small FIFO and presents it on a valid/ready link toward the neighbouring node.
- Its ready/grant pair drives the matching bit of each input buffer's obuf_rdy / arb_gnt vectors.

---
 rtl/obuf_arb_data.sv | 108 ++++++++++
 tb/tb_obuf_arb_data.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/obuf_arb_data.sv
`default_nettype none
// ============================================================================
// Module  : obuf_arb_data
// Brief   : Output-port stage. Round-robin arbiter over five input buffers
//           feeding a small FIFO with a valid/ready link to the neighbour.
// Rev     : 1.0
// ============================================================================
module obuf_arb_data #(
  parameter int PYLD_W = 23,
  parameter int NREQ   = 5,
  parameter int DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ*PYLD_W-1:0]       pyld_in,
  input  logic                         pg_en,
  output logic [NREQ-1:0]              gnt,
  output logic                         obuf_rdy,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic [PYLD_W-1:0]            out_pyld,
  output logic [$clog2(DEPTH):0]       occ
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PYLD_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [IDX_W-1:0]  r_rr_ptr;

  logic              w_found;
  logic [IDX_W-1:0]  w_sel;
  logic [IDX_W-1:0]  w_cand;
  logic [IDX_W:0]    w_sum;
  logic [IDX_W-1:0]  w_rr_next;
  logic [PYLD_W-1:0] w_pyld;
  logic              w_accept;
  logic              w_pop;

  // Qualified by rst_n so no grant can escape while the port is held in reset.
  assign obuf_rdy = rst_n & (r_count < CNT_W'(DEPTH)) & ~pg_en;

  // Rotating first-found search starting at r_rr_ptr, modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_sum   = '0;
    w_cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(i);
      if (w_sum >= (IDX_W+1)'(NREQ))
        w_sum = w_sum - (IDX_W+1)'(NREQ);
      w_cand = w_sum[IDX_W-1:0];
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_sel   = w_cand;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (obuf_rdy && w_found)
      gnt[w_sel] = 1'b1;
  end

  always_comb begin
    w_pyld = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (w_sel == IDX_W'(j))
        w_pyld = pyld_in[j*PYLD_W +: PYLD_W];
    end
  end

  assign w_rr_next = (w_sel == IDX_W'(NREQ-1)) ? '0 : w_sel + 1'b1;
  assign w_accept  = |gnt;
  assign out_vld   = (r_count != '0);
  assign w_pop     = out_vld & out_rdy;
  assign out_pyld  = r_mem[r_rd_ptr];
  assign occ       = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rr_ptr <= '0;
      for (int d = 0; d < DEPTH; d++)
        r_mem[d] <= '0;
    end else begin
      if (w_accept) begin
        r_mem[r_wr_ptr] <= w_pyld;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
        r_rr_ptr        <= w_rr_next;
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{PTR_W{1'b0}}, w_accept} - {{PTR_W{1'b0}}, w_pop};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_obuf_arb_data.sv
`default_nettype none
// ============================================================================
// Module  : tb_obuf_arb_data
// Brief   : Directed scoreboard bench for obuf_arb_data.
// Rev     : 1.0
// ============================================================================
module tb_obuf_arb_data;

  localparam int PYLD_W = 23;
  localparam int NREQ   = 5;
  localparam int DEPTH  = 2;

  logic                   clk;
  logic                   rst_n;
  logic [NREQ-1:0]        req;
  logic [NREQ*PYLD_W-1:0] pyld_in;
  logic                   pg_en;
  logic [NREQ-1:0]        gnt;
  logic                   obuf_rdy;
  logic                   out_vld;
  logic                   out_rdy;
  logic [PYLD_W-1:0]      out_pyld;
  logic [$clog2(DEPTH):0] occ;

  logic [PYLD_W-1:0] pv [NREQ];
  logic [PYLD_W-1:0] sb [$];
  int n_chk  = 0;
  int n_fail = 0;

  obuf_arb_data #(.PYLD_W(PYLD_W), .NREQ(NREQ), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .pyld_in  (pyld_in),
    .pg_en    (pg_en),
    .gnt      (gnt),
    .obuf_rdy (obuf_rdy),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_pyld (out_pyld),
    .occ      (occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [PYLD_W-1:0] base);
    for (int i = 0; i < NREQ; i++) begin
      pv[i] = base + PYLD_W'(i);
      pyld_in[i*PYLD_W +: PYLD_W] = pv[i];
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Monitor: every accepted output beat is checked against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_vld && out_rdy) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got %0h expected none", out_pyld);
      end else begin
        if (out_pyld !== sb[0]) begin
          n_fail++;
          $display("FAIL pop_data: got %0h expected %0h", out_pyld, sb[0]);
        end
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req = 5'h1f; pg_en = 1'b0; out_rdy = 1'b0;
    pyld_in = '0;
    load('0);
    mid();
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_obuf_rdy", 32'(obuf_rdy), 0);
    chk("rst_out_vld", 32'(out_vld), 0);
    chk("rst_occ", 32'(occ), 0);
    chk("rst_out_pyld", 32'(out_pyld), 0);

    cyc(); rst_n = 1'b1; req = '0;
    mid();
    chk("idle_obuf_rdy", 32'(obuf_rdy), 1);

    // Single requester
    cyc(); req = 5'b00100; load(23'h12343); out_rdy = 1'b1;
    mid();
    chk("single_gnt", 32'(gnt), 32'b00100);
    sb.push_back(pv[2]);
    cyc(); req = '0;
    mid();
    chk("single_vld", 32'(out_vld), 1);
    chk("single_occ", 32'(occ), 1);
    chk("single_gnt_idle", 32'(gnt), 0);

    // Fairness, pointer left at 3 by the single grant
    for (int k = 0; k < 6; k++) begin
      cyc(); req = 5'h1f; load(23'h20000 + PYLD_W'(k * 16));
      mid();
      chk("rr_gnt", 32'(gnt), 32'(5'b1 << ((3 + k) % 5)));
      sb.push_back(pv[(3 + k) % 5]);
    end
    cyc(); req = '0;
    mid();
    chk("rr_drain_occ1", 32'(occ), 1);
    cyc();
    mid();
    chk("rr_drain_occ0", 32'(occ), 0);
    chk("rr_drain_vld", 32'(out_vld), 0);

    // Backpressure, pointer at 4
    cyc(); out_rdy = 1'b0; req = 5'b00011; load(23'h3a000);
    mid();
    chk("bp_gnt_a", 32'(gnt), 32'b00001);
    sb.push_back(pv[0]);
    cyc(); load(23'h3b000);
    mid();
    chk("bp_gnt_b", 32'(gnt), 32'b00010);
    sb.push_back(pv[1]);
    cyc();
    mid();
    chk("bp_full_occ", 32'(occ), 2);
    chk("bp_full_rdy", 32'(obuf_rdy), 0);
    chk("bp_full_gnt", 32'(gnt), 0);
    cyc(); out_rdy = 1'b1;
    mid();
    chk("fullpop_occ", 32'(occ), 2);
    chk("fullpop_gnt", 32'(gnt), 0);
    cyc(); out_rdy = 1'b0; load(23'h3c000);
    mid();
    chk("afterpop_occ", 32'(occ), 1);
    chk("afterpop_gnt", 32'(gnt), 32'b00001);
    sb.push_back(pv[0]);
    cyc();
    mid();
    chk("refill_occ", 32'(occ), 2);
    chk("refill_gnt", 32'(gnt), 0);

    // Power gate, pointer at 1
    cyc(); pg_en = 1'b1; req = 5'h1f; out_rdy = 1'b1;
    mid();
    chk("pg_gnt0", 32'(gnt), 0);
    chk("pg_occ2", 32'(occ), 2);
    cyc();
    mid();
    chk("pg_gnt1", 32'(gnt), 0);
    chk("pg_occ1", 32'(occ), 1);
    cyc();
    mid();
    chk("pg_gnt2", 32'(gnt), 0);
    chk("pg_occ0", 32'(occ), 0);
    chk("pg_vld0", 32'(out_vld), 0);
    cyc(); pg_en = 1'b0; load(23'h4d000);
    mid();
    chk("pg_release_gnt", 32'(gnt), 32'b00010);
    sb.push_back(pv[1]);
    cyc(); req = '0;
    mid();
    chk("pg_post_occ1", 32'(occ), 1);
    cyc();
    mid();
    chk("pg_post_occ0", 32'(occ), 0);

    // Reset mid-stream; entries granted here are discarded by the reset
    cyc(); out_rdy = 1'b0; req = 5'h1f; load(23'h5e000);
    mid();
    chk("mr_gnt2", 32'(gnt), 32'b00100);
    cyc();
    mid();
    chk("mr_gnt3", 32'(gnt), 32'b01000);
    cyc();
    mid();
    chk("mr_occ2", 32'(occ), 2);
    chk("mr_vld1", 32'(out_vld), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_vld_async", 32'(out_vld), 0);
    chk("mr_occ_async", 32'(occ), 0);
    chk("mr_gnt_async", 32'(gnt), 0);
    cyc(); rst_n = 1'b1; req = 5'b10000; load(23'h6f000);
    mid();
    chk("mr_wrap_gnt", 32'(gnt), 32'b10000);
    sb.push_back(pv[4]);
    cyc(); req = '0; out_rdy = 1'b1;
    mid();
    chk("mr_vld_after", 32'(out_vld), 1);
    cyc();
    mid();
    chk("final_occ", 32'(occ), 0);
    chk("final_sb_empty", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
